// File: rtl/wide_add_pkg.sv
// wide_add_pkg
//   Shared definitions for the wide add sequencer.
//   DATA_W  : width of one adder-core slice.
//   state_t : sequencer FSM states.
package wide_add_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Feeds a WORDS x 32-bit add request through an external 32-bit adder core,
//   one slice per clock, least significant slice first. The carry out of each
//   slice is chained into the carry in of the next one. The slice sums are
//   collected into a wide result, which is offered on a valid/ready port.
//
//   Optional build macro: WIDE_ADD_SUB_EN adds in_sub. When in_sub is set at
//   accept, the sequencer computes A - B: it stores ~B and forces the initial
//   carry to 1, ignoring in_cin.
//
//   Ports
//     clk, rst       : clock (rising edge), asynchronous active-high reset
//     in_valid/ready : request handshake. in_ready is high only in IDLE.
//     in_a, in_b     : WORDS*32-bit operands
//     in_cin         : initial carry in
//     in_sub         : subtract select (present only with WIDE_ADD_SUB_EN)
//     add_a/b/cin    : slice operands to the adder core. They are zero outside RUN.
//     add_result     : adder core sum. Bit 32 is the carry out.
//     add_overflow   : adder core signed overflow for the current slice
//     out_valid/ready: result handshake
//     out_sum        : WORDS*32-bit sum
//     out_cout       : carry out of the most significant slice
//     out_overflow   : adder overflow flag of the most significant slice
//     busy           : high in RUN or DONE
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*DATA_W-1:0]  in_a,
    input  logic [WORDS*DATA_W-1:0]  in_b,
    input  logic                     in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                     in_sub,
`endif
    output logic [DATA_W-1:0]        add_a,
    output logic [DATA_W-1:0]        add_b,
    output logic                     add_cin,
    input  logic [DATA_W:0]          add_result,
    input  logic                     add_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*DATA_W-1:0]  out_sum,
    output logic                     out_cout,
    output logic                     out_overflow,
    output logic                     busy
);

    localparam int W     = WORDS * DATA_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef WIDE_ADD_SUB_EN
                    // A - B is computed as A + ~B + 1.
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
`else
                    b_d     = in_b;
                    carry_d = in_cin;
`endif
                end
            end
            RUN: begin
                sum_d[idx_q*DATA_W +: DATA_W] = add_result[DATA_W-1:0];
                carry_d = add_result[DATA_W];
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_result[DATA_W];
                    ovf_d   = add_overflow;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // The adder operands come only from registers, so no in_* path reaches
    // the core. They are held at zero outside RUN to keep the core quiet.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q*DATA_W +: DATA_W];
            add_b   = b_q[idx_q*DATA_W +: DATA_W];
            add_cin = carry_q;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q == RUN) || (state_q == DONE);
    assign out_sum      = sum_q;
    assign out_cout     = cout_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer
//   Bench for wide_add_sequencer with WORDS=4. A behavioural 32-bit adder core
//   is connected to the add_* ports. The bench runs a table of fixed vectors,
//   several hand-written sequences (backpressure, reset in mid-RUN) and
//   randomized requests. Random results are checked against full-width
//   arithmetic.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready;
    logic [W-1:0]   in_a, in_b;
    logic           in_cin, in_sub;
    logic [31:0]    add_a, add_b;
    logic           add_cin;
    logic [32:0]    add_result;
    logic           add_overflow;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_sum;
    logic           out_cout, out_overflow, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural adder core
    always_comb begin
        add_result   = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        add_overflow = (add_a[31] == add_b[31]) && (add_result[31] != add_a[31]);
    end

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_cin       (in_cin),
`ifdef WIDE_ADD_SUB_EN
        .in_sub       (in_sub),
`endif
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_result   (add_result),
        .add_overflow (add_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // This is the carry into slice k of a wide add. It is the carry out of
    // the low k*32 bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input int k);
        logic [W:0] lo;
        logic [W:0] mask;
        if (k == 0) return cin;
        mask = ({{W{1'b0}}, 1'b1} << (k * 32)) - 1;
        lo = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, cin};
        return lo[k*32];
    endfunction

    // This task issues one request and checks each RUN slice, the latency and
    // the result. It finishes with the output handshake. sub selects
    // subtraction, which exists only in builds with WIDE_ADD_SUB_EN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input string tag);
        logic [W-1:0] b_eff;
        logic         c_eff;
        int           lat;
        b_eff = sub ? ~b : b;
        c_eff = sub ? 1'b1 : cin;
        chk({tag, "_in_ready"}, in_ready, 1);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = rnd_w(); in_b = rnd_w(); in_cin = ~cin; in_sub = 1'b0;
        lat = 0;
        for (int n = 1; n <= WORDS + 3; n++) begin
            if (busy && !out_valid && n <= WORDS) begin
                chk($sformatf("%s_add_a%0d", tag, n-1), add_a, a[(n-1)*32 +: 32]);
                chk($sformatf("%s_add_b%0d", tag, n-1), add_b, b_eff[(n-1)*32 +: 32]);
                chk($sformatf("%s_add_cin%0d", tag, n-1), add_cin,
                    carry_into(a, b_eff, c_eff, n-1));
            end
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        chk({tag, "_latency"}, lat, WORDS);
        chk({tag, "_sum"}, out_sum, e_sum);
        chk({tag, "_cout"}, out_cout, e_cout);
        chk({tag, "_ovf"}, out_overflow, e_ovf);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_sum_kept"}, out_sum, e_sum);
        chk({tag, "_idle_add_a"}, add_a, 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] ones, msb, ra, rb, hold_sum;
        logic [W:0]   full;
        logic         rc, ovf;
        int           lat;

        ones = '1;
        msb  = '0; msb[W-1] = 1'b1;
        vecs[0] = '{a: W'(32'hFFFF_FFFF), b: W'(1), cin: 0, sum: W'(64'h1_0000_0000), cout: 0, ovf: 0};
        vecs[1] = '{a: ones, b: '0, cin: 1, sum: '0, cout: 1, ovf: 0};
        vecs[2] = '{a: ~msb, b: W'(1), cin: 0, sum: msb, cout: 0, ovf: 1};
        vecs[3] = '{a: W'(3), b: W'(4), cin: 0, sum: W'(7), cout: 0, ovf: 0};
        vecs[4] = '{a: ones, b: ones, cin: 1, sum: ones, cout: 1, ovf: 0};
        vecs[5] = '{a: msb, b: msb, cin: 0, sum: '0, cout: 1, ovf: 1};

        rst = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // out_ready outside DONE has no effect
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_ready_ignored", {out_valid, busy}, 0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));

        // Backpressure: the result is held while a new request waits.
        in_a = W'(100); in_b = W'(23); in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        ra = rnd_w(); rb = rnd_w(); rc = 1'b0;
        in_a = ra; in_b = rb; in_cin = rc;
        lat = 0;
        for (int n = 1; n <= WORDS + 3; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        chk("bp_latency", lat, WORDS);
        hold_sum = out_sum;
        chk("bp_sum", hold_sum, W'(124));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_sum%0d", c), out_sum, W'(124));
            chk($sformatf("bp_hold_vld%0d", c), out_valid, 1);
            chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_after_hs_ready", in_ready, 1);
        chk("bp_after_hs_busy", busy, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = rnd_w(); in_b = rnd_w();
        chk("bp_second_busy", busy, 1);
        lat = 0;
        for (int n = 1; n <= WORDS + 3; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        chk("bp_second_latency", lat, WORDS);
        chk("bp_second_sum", out_sum, full[W-1:0]);
        chk("bp_second_cout", out_cout, full[W]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during RUN at idx 2
        in_a = ones; in_b = ones; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_add_a_idx2", add_a, 32'hFFFF_FFFF);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_sum", out_sum, 0);
        chk("mrst_cout_ovf", {out_cout, out_overflow}, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_add", {add_a, add_b, add_cin}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(W'(3), W'(4), 1'b0, 1'b0, W'(7), 1'b0, 1'b0, "post_rst");

`ifdef WIDE_ADD_SUB_EN
        run_op(W'(5), W'(7), 1'b0, 1'b1, ~W'(1), 1'b0, 1'b0, "sub_5_7");
        run_op(W'(7), W'(5), 1'b1, 1'b1, W'(2), 1'b1, 1'b0, "sub_7_5");
`endif

        // Randomized requests vs full-width arithmetic
        for (int i = 0; i < 20; i++) begin
            ra = rnd_w(); rb = rnd_w(); rc = 1'($urandom_range(0, 1));
            if (i % 5 == 0) rb = ~ra;
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            ovf  = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            run_op(ra, rb, rc, 1'b0, full[W-1:0], full[W], ovf, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle operand sequencer placed in front of the team's 32-bit adder core, which has ports A[31:0], B[31:0], Cin, Result[32:0] and Overflow.
- Accepts one WORDS×32-bit add request and feeds the core one 32-bit slice per cycle, LSW first. The carry from Result[32] is chained into the next slice's Cin.
- Collects the slice sums into a wide result and presents it on a valid/ready output.
- Because it both feeds and consumes the adder, every adder architecture can be exercised at widths beyond 32 bits.

Parameters:
- WORDS, 4, number of 32-bit slices per operation (legal range ≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready at a clk edge.
- in_a  in  WORDS*32  operand A.
- in_b  in  WORDS*32  operand B.
- in_cin  in  1  initial carry-in.
- add_a  out  32  adder core A.
- add_b  out  32  adder core B.
- add_cin  out  1  adder core Cin.
- add_result  in  33  adder core Result (bit 32 = carry out).
- add_overflow  in  1  adder core Overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&out_ready at a clk edge.
- out_sum  out  WORDS*32  wide sum.
- out_cout  out  1  final carry out.
- out_overflow  out  1  adder Overflow for the most-significant slice.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset clears all registers and sets the FSM to IDLE.
- Reset values of outputs: out_valid=0, out_sum=0, out_cout=0, out_overflow=0, busy=0, add_a/add_b/add_cin=0.
- in_ready is 1 in IDLE. No handshake is taken while rst is high.
- FSM IDLE: in_ready=1.
  - On accept: latch in_a, in_b into operand regs; carry_reg<=in_cin; idx<=0; go to RUN.
- FSM RUN: add_a=a_reg[idx*32+:32], add_b=b_reg[idx*32+:32], add_cin=carry_reg. All three are driven from registers only, with no combinational path from in_* ports.
  - Each edge: sum_reg[idx*32+:32]<=add_result[31:0]; carry_reg<=add_result[32]; idx<=idx+1.
  - On the idx==WORDS-1 edge: also latch out_cout<=add_result[32] and out_overflow<=add_overflow, then go to DONE.
- FSM DONE: out_valid=1. out_sum, out_cout and out_overflow are held stable until out_ready.
  - On handshake: go to IDLE. out_valid drops next cycle; out_sum keeps its last value.
- Adder inputs outside RUN: driven 0 to suppress toggling in power runs.
- Latency: out_valid rises exactly WORDS edges after the accept edge. Minimum initiation interval is WORDS+2 cycles. No accept is taken in RUN or DONE.
- Data integrity: changes on in_a/in_b after accept have no effect. The adder core is purely combinational and must settle within one clk period.
- WORDS=1: RUN lasts one cycle. idx width = max(1,$clog2(WORDS)); idx never exceeds WORDS-1.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values. The partial result is discarded.
- out_ready high outside DONE is ignored. in_valid held during RUN is not accepted until IDLE.

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined: adds port in_sub (in, 1), latched on accept. When in_sub=1, b_reg stores ~in_b and carry_reg<=1, with in_cin ignored; the result is A−B in two's complement.
- Undefined: port absent, addition only.

Decomposition:
- Package wide_add_pkg: localparam DATA_W=32, and typedef enum logic[1:0] {IDLE, RUN, DONE} state_t.
- No sub-module. The adder core is instantiated beside this block in the enclosing test wrapper and connected through the add_* ports, so any adder architecture can be swapped in.

Test Plan:
- WORDS=4: a=0x...0000_FFFF_FFFF, b=1, cin=0 → out_sum=0x...0001_0000_0000, cout=0, out_valid exactly 4 edges after accept.
- a=all-ones (128b), b=0, cin=1 → out_sum=0, out_cout=1, add_cin observed 1,1,1,1 across RUN.
- a=0x7FFF_FFFF_FFFF..FF, b=1, cin=0 → out_sum=0x8000_0000_0000..00, out_overflow=1, out_cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → outputs stable, in_ready=0, new request accepted only after the out handshake, and it produces its own correct sum.
- Assert rst at idx=2 of RUN → all outputs 0 asynchronously, state IDLE. Next request a=3, b=4 → out_sum=7.
- WIDE_ADD_SUB_EN: a=5, b=7, in_sub=1 → out_sum=0xFFFF..FFFE, out_cout=0. With a=7, b=5 → out_sum=2, out_cout=1.
